icache_fill_responder: RTL
==========================

// Module: icache_fill_responder
// PURPOSE
//  Memory-side responder for I$ line-fill requests issued by the fetch stage on a miss.
//  - Accepts one deserialized read request (line address plus requester dest ID).
//  - Reads the 128-bit line from the memory array.
//  - Arbitrates for the shared bus with the SER req/grant/release handshake.
//  - Returns the line as four 32-bit beats, each acknowledged by the requester's DES ack.
//  - Services one request at a time.
// PARAMETERS
//  LINE_BITS  128  cache line width; fixed at 4 beats
//  BEAT_BITS  32   bus data beat width
//  MEM_LAT    2    cycles from mem_rd_en to mem_rd_data valid (1..7)
// PORTS
//  clk          in   1    single clock; all state updates on posedge
//  reset        in   1    asynchronous, active-low reset
//  req_valid    in   1    fill request present
//  req_ready    out  1    responder can accept a request (IDLE only)
//  req_addr     in   30   word address [31:2] of the missing fetch
//  req_dest     in   4    bus dest ID of the requesting DES (even/odd I$)
//  mem_rd_en    out  1    one-cycle memory read strobe
//  mem_rd_addr  out  28   line address [31:4]
//  mem_rd_data  in   128  line data, valid MEM_LAT cycles after mem_rd_en
//  mem_rd_err   in   1    sampled with mem_rd_data; uncorrectable/invalid read
//  SER_req      out  1    bus request, held until release
//  SER_grant    in   1    bus grant from arbiter
//  SER_release  out  1    one-cycle bus release pulse
//  BUS_drive    out  1    beat on BUS_* is valid this cycle
//  BUS_data     out  32   beat payload
//  BUS_dest     out  4    latched req_dest
//  BUS_beat     out  2    word index within the line of the current beat
//  BUS_last     out  1    current beat is the 4th beat
//  BUS_err      out  1    latched mem_rd_err; constant for all beats of the line
//  DES_ack      in   1    requester accepted the current beat
//  busy         out  1    FSM not IDLE
// BEHAVIOUR
//  - Reset (async, active-low): FSM=IDLE; beat counter=0; all outputs 0 except req_ready=1.
//    The data latch is not reset. Reset mid-transfer aborts it with no release pulse;
//    the arbiter sees SER_req drop.
//  - IDLE: req_ready=1. On req_valid, latch req_addr and req_dest, pulse mem_rd_en with
//    mem_rd_addr=req_addr[31:4], and go to MEM_RD.
//  - MEM_RD: a 3-bit counter counts MEM_LAT cycles. On the last count, latch mem_rd_data
//    and mem_rd_err, then go to WAIT_GRANT.
//  - WAIT_GRANT: SER_req=1. If SER_grant is sampled high, go to SEND on the next cycle.
//  - SEND:
//    - SER_req=1, BUS_drive=1, BUS_data=line[32*BUS_beat +: 32].
//    - On DES_ack, advance the beat. BUS_data is held stable while DES_ack=0.
//    - On DES_ack of beat 4 (BUS_last=1), go to RELEASE.
//    - If SER_grant drops before the last ack: BUS_drive=0 next cycle, the beat counter
//      is held, and the FSM returns to WAIT_GRANT; that beat is resent after re-grant.
//    - DES_ack outside SEND is ignored.
//  - RELEASE: SER_req=0, SER_release=1 for exactly one cycle, then IDLE.
//  - req_valid outside IDLE is not accepted (req_ready=0); the requester must hold it.
//  - Best-case latency, req accept to first beat: 1 + MEM_LAT + 1 (grant) cycles.
//  - Beat index: 2-bit counter, wraps modulo 4. BUS_last=1 when beats_sent==3,
//    independent of start index.
// CONFIGURATION
//  FILL_CRIT_WORD_FIRST_EN defined: the first beat is word req_addr[3:2]; later beats
//    wrap (e.g. 2,3,0,1) so fetch can restart on the critical word early.
//  Undefined: beats are always sent in order 0,1,2,3; req_addr[3:2] is ignored.
// STRUCTURE
//  - Shared package (mem_bus_pkg): FSM state encoding {IDLE,MEM_RD,WAIT_GRANT,SEND,RELEASE};
//    BEATS_PER_LINE=4; the I$ even/odd dest ID constants.
//  - One sub-module: line_beat_mux (128-bit latch + 4:1 32-bit beat select by BUS_beat).
// TESTING
//  - Basic fill: req_addr=0x0000_1234 (line 0x123), dest=4'h2, MEM_LAT=2, grant immediate,
//    ack every cycle -> mem_rd_addr=0x0000123, 4 beats words 0..3, BUS_last on the 4th,
//    one SER_release pulse, req_ready back to 1.
//  - Ack backpressure: DES_ack low 3 cycles on beat 1 -> BUS_data/BUS_beat stable,
//    no beat skipped, exactly 4 beats.
//  - Grant loss: drop SER_grant after beat 1 ack -> BUS_drive=0, SER_req stays 1;
//    re-grant -> resumes at beat 2, no duplicate of beat 1.
//  - Critical word (macro on): req_addr[3:2]=2'b10 -> BUS_beat sequence 2,3,0,1,
//    BUS_last with beat 1. Macro off -> 0,1,2,3.
//  - Error: mem_rd_err=1 -> BUS_err=1 on all 4 beats; normal release.
//  - Reset mid-SEND: assert reset after beat 2 -> outputs zero immediately, no
//    SER_release; next request completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions for the I$ fill responder: FSM encoding, line geometry and
// the destination IDs of the even/odd instruction-cache DES endpoints.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMemRd,
    StWaitGrant,
    StSend,
    StRelease
  } fill_state_e;

  localparam int unsigned BEATS_PER_LINE = 4;

  localparam logic [3:0] DEST_ICACHE_EVEN = 4'h2;
  localparam logic [3:0] DEST_ICACHE_ODD  = 4'h3;

endpackage

// File: rtl/line_beat_mux.sv
// Holds one fetched cache line and selects the 32-bit beat addressed by i_sel.
// The line register is deliberately not reset; it is always loaded before use.
module line_beat_mux #(
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned BEAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 i_load,
  input  logic [LINE_BITS-1:0] i_line,
  input  logic [1:0]           i_sel,
  output logic [BEAT_BITS-1:0] o_beat
);

  logic [LINE_BITS-1:0] r_line;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_line <= i_line;
    end
  end

  assign o_beat = r_line[BEAT_BITS*i_sel +: BEAT_BITS];

endmodule

// File: rtl/icache_fill_responder.sv
// Memory-side responder for I$ line fills: reads a line, wins the shared bus, sends 4 beats.
// Define FILL_CRIT_WORD_FIRST_EN to start each fill at the requested (critical) word.
module icache_fill_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned BEAT_BITS = 32,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [29:0]          req_addr,
  input  logic [3:0]           req_dest,
  output logic                 mem_rd_en,
  output logic [27:0]          mem_rd_addr,
  input  logic [LINE_BITS-1:0] mem_rd_data,
  input  logic                 mem_rd_err,
  output logic                 SER_req,
  input  logic                 SER_grant,
  output logic                 SER_release,
  output logic                 BUS_drive,
  output logic [BEAT_BITS-1:0] BUS_data,
  output logic [3:0]           BUS_dest,
  output logic [1:0]           BUS_beat,
  output logic                 BUS_last,
  output logic                 BUS_err,
  input  logic                 DES_ack,
  output logic                 busy
);

`ifdef FILL_CRIT_WORD_FIRST_EN
  localparam bit CritWordFirst = 1'b1;
`else
  localparam bit CritWordFirst = 1'b0;
`endif

  fill_state_e          r_state, w_state_next;
  logic [2:0]           r_lat_cnt, w_lat_cnt_next;
  logic [1:0]           r_sent, w_sent_next;
  logic [1:0]           r_start;
  logic [3:0]           r_dest;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_line_load;
  logic                 w_last;
  logic [1:0]           w_start_word;
  logic [1:0]           w_beat;
  logic [BEAT_BITS-1:0] w_beat_data;

  // Word index within the line: req_addr is a word address, so [1:0] is byte addr [3:2].
  assign w_start_word = req_addr[1:0] & {2{CritWordFirst}};
  assign w_beat       = r_start + r_sent;
  assign w_last       = (r_sent == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_lat_cnt <= 3'd0;
      r_sent    <= 2'd0;
      r_start   <= 2'd0;
      r_dest    <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_cnt_next;
      r_sent    <= w_sent_next;
      if (w_accept) begin
        r_start <= w_start_word;
        r_dest  <= req_dest;
      end
      if (w_line_load) begin
        r_err <= mem_rd_err;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    w_sent_next    = r_sent;
    w_accept       = 1'b0;
    w_line_load    = 1'b0;
    req_ready      = 1'b0;
    SER_req        = 1'b0;
    SER_release    = 1'b0;
    BUS_drive      = 1'b0;
    case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept       = 1'b1;
          w_lat_cnt_next = 3'd0;
          w_sent_next    = 2'd0;
          w_state_next   = StMemRd;
        end
      end
      StMemRd: begin
        if (r_lat_cnt == 3'(MEM_LAT - 1)) begin
          w_line_load  = 1'b1;
          w_state_next = StWaitGrant;
        end else begin
          w_lat_cnt_next = r_lat_cnt + 3'd1;
        end
      end
      StWaitGrant: begin
        SER_req = 1'b1;
        if (SER_grant) begin
          w_state_next = StSend;
        end
      end
      StSend: begin
        SER_req   = 1'b1;
        BUS_drive = 1'b1;
        // Losing the grant wins over a same-cycle ack: the beat is resent after re-grant.
        if (!SER_grant) begin
          w_state_next = StWaitGrant;
        end else if (DES_ack) begin
          w_sent_next = r_sent + 2'd1;
          if (w_last) begin
            w_state_next = StRelease;
          end
        end
      end
      StRelease: begin
        SER_release  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign mem_rd_en   = w_accept;
  assign mem_rd_addr = w_accept ? req_addr[29:2] : 28'd0;
  assign busy        = (r_state != StIdle);
  assign BUS_beat    = w_beat;
  assign BUS_last    = BUS_drive & w_last;
  assign BUS_dest    = r_dest;
  assign BUS_err     = r_err;
  assign BUS_data    = BUS_drive ? w_beat_data : '0;

  line_beat_mux #(
    .LINE_BITS(LINE_BITS),
    .BEAT_BITS(BEAT_BITS)
  ) u_line_beat_mux (
    .clk   (clk),
    .i_load(w_line_load),
    .i_line(mem_rd_data),
    .i_sel (w_beat),
    .o_beat(w_beat_data)
  );

endmodule
